// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the 2-read/1-write register file.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/regfile_if.sv
// Write, read and status signals of the register file, grouped as one bus.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int ADDR_W = $clog2(DEPTH);

  logic              clear;
  logic              ld;
  logic [ADDR_W-1:0] d_select;
  logic [WIDTH-1:0]  input_data;
  logic [ADDR_W-1:0] m1_select;
  logic [ADDR_W-1:0] m2_select;
  logic [WIDTH-1:0]  rdata1;
  logic [WIDTH-1:0]  rdata2;
  logic              ready;

  modport master (
    output clear, ld, d_select, input_data, m1_select, m2_select,
    input  rdata1, rdata2, ready
  );

  modport slave (
    input  clear, ld, d_select, input_data, m1_select, m2_select,
    output rdata1, rdata2, ready
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: storage mux, write-first bypass and output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic [ADDR_W-1:0] sel_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [WIDTH-1:0]  mem_i [DEPTH],
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // wr_en_i already excludes suppressed writes, so a hit always forwards
  always_comb begin
    rdata_d = mem_i[sel_i];
    if (wr_en_i && (wr_addr_i == sel_i)) rdata_d = wr_data_i;
    if ((ZERO_REG != 0) && (sel_i == '0)) rdata_d = '0;
    if (!run_i) rdata_d = '0;
  end

  // output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one write port, two bypassed registered read ports and a
// clear sweep that zeroes every entry after reset or on request.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  regfile_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              run;
  logic              wr_en;
  logic [WIDTH-1:0]  rdata1_w;
  logic [WIDTH-1:0]  rdata2_w;

  assign run   = (state_q == RUN);
  // a clear in the same cycle discards the write
  assign wr_en = run && bus.ld && !bus.clear &&
                 !((ZERO_REG != 0) && (bus.d_select == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (bus.clear) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // storage has no reset; the sweep is what zeroes it
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run)       mem_q[cnt_q]        <= '0;
      else if (wr_en) mem_q[bus.d_select] <= bus.input_data;
    end
  end

  regfile_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (run),
    .sel_i     (bus.m1_select),
    .wr_en_i   (wr_en),
    .wr_addr_i (bus.d_select),
    .wr_data_i (bus.input_data),
    .mem_i     (mem_q),
    .rdata_o   (rdata1_w)
  );

  regfile_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (run),
    .sel_i     (bus.m2_select),
    .wr_en_i   (wr_en),
    .wr_addr_i (bus.d_select),
    .wr_data_i (bus.input_data),
    .mem_i     (mem_q),
    .rdata_o   (rdata2_w)
  );

  assign bus.rdata1 = rdata1_w;
  assign bus.rdata2 = rdata2_w;
  assign bus.ready  = run;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: ZERO_REG=0 and ZERO_REG=1 copies driven in lockstep.
module tb_regfile_2r1w;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_if #(.WIDTH(32), .DEPTH(16)) bus0 ();
  regfile_if #(.WIDTH(32), .DEPTH(16)) bus1 ();

  regfile_2r1w #(.WIDTH(32), .DEPTH(16), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  regfile_2r1w #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct packed {
    logic [31:0] r1_0, r2_0, r1_1, r2_1;
    logic        rdy0, rdy1, chk;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mdl_mem [2][16];
  bit          mdl_run [2];
  int          mdl_left[2];

  // Reference: a sweep is a countdown of 16 active edges after which the
  // whole array is zero; running reads/writes follow write-first semantics.
  function automatic void model_edge(input int k, input logic rstn, clr, ldv,
                                     input logic [3:0] d, input logic [31:0] data,
                                     input logic [3:0] a1, a2,
                                     output logic [31:0] r1, r2,
                                     output logic rdy, chk);
    bit zr;
    bit wr;
    zr  = (k == 1);
    r1  = 32'd0;
    r2  = 32'd0;
    chk = 1'b1;
    if (!rstn) begin
      mdl_run[k]  = 1'b0;
      mdl_left[k] = 16;
    end else if (!mdl_run[k]) begin
      mdl_left[k]--;
      if (mdl_left[k] == 0) begin
        for (int i = 0; i < 16; i++) mdl_mem[k][i] = 32'd0;
        mdl_run[k] = 1'b1;
      end
    end else if (clr) begin
      mdl_run[k]  = 1'b0;
      mdl_left[k] = 16;
      chk         = 1'b0;
    end else begin
      wr = ldv && !(zr && d == 4'd0);
      r1 = (zr && a1 == 4'd0) ? 32'd0 : (wr && d == a1) ? data : mdl_mem[k][a1];
      r2 = (zr && a2 == 4'd0) ? 32'd0 : (wr && d == a2) ? data : mdl_mem[k][a2];
      if (wr) mdl_mem[k][d] = data;
    end
    rdy = mdl_run[k];
  endfunction

  task automatic step(input logic rstn, clr, ldv, input logic [3:0] d,
                      input logic [31:0] data, input logic [3:0] a1, a2);
    exp_t e;
    @(negedge clk);
    rst_n = rstn;
    bus0.clear = clr;  bus1.clear = clr;
    bus0.ld = ldv;     bus1.ld = ldv;
    bus0.d_select = d; bus1.d_select = d;
    bus0.input_data = data; bus1.input_data = data;
    bus0.m1_select = a1; bus1.m1_select = a1;
    bus0.m2_select = a2; bus1.m2_select = a2;
    model_edge(0, rstn, clr, ldv, d, data, a1, a2, e.r1_0, e.r2_0, e.rdy0, e.chk);
    model_edge(1, rstn, clr, ldv, d, data, a1, a2, e.r1_1, e.r2_1, e.rdy1, e.chk);
    sb.push_back(e);
  endtask

  task automatic wr(input logic [3:0] d, input logic [31:0] data, input logic [3:0] a1, a2);
    step(1'b1, 1'b0, 1'b1, d, data, a1, a2);
  endtask

  task automatic rd(input logic [3:0] a1, a2);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, a1, a2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(4'($urandom_range(15)), 4'($urandom_range(15)));
  endtask

  task automatic check(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ready0", {31'd0, bus0.ready}, {31'd0, e.rdy0});
        check("ready1", {31'd0, bus1.ready}, {31'd0, e.rdy1});
        if (e.chk) begin
          check("dut0 rdata1", bus0.rdata1, e.r1_0);
          check("dut0 rdata2", bus0.rdata2, e.r2_0);
          check("dut1 rdata1", bus1.rdata1, e.r1_1);
          check("dut1 rdata2", bus1.rdata2, e.r2_1);
        end
      end
    end
  end

  initial begin
    logic [3:0] a;
    logic [3:0] b;
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 4'd3, 32'h5555_5555, 4'd1, 4'd2);

    // power-up sweep, then every register reads zero
    idle(16);
    for (int i = 0; i < 16; i++) begin a = 4'(i); b = 4'(15 - i); rd(a, b); end

    // fill and read back ascending / descending
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hFFFF_FF00 + 32'(i), 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin a = 4'(i); b = 4'(15 - i); rd(a, b); end

    // write-first bypass
    wr(4'd5, 32'h1111_1111, 4'd0, 4'd1);
    wr(4'd5, 32'hDEAD_BEEF, 4'd5, 4'd5);
    rd(4'd5, 4'd5);

    // register 0 writes (ignored on the ZERO_REG copy) and register 1
    wr(4'd0, 32'h1234_5678, 4'd0, 4'd0);
    rd(4'd0, 4'd0);
    wr(4'd1, 32'hCAFE_0001, 4'd1, 4'd0);
    rd(4'd1, 4'd0);

    // clear together with a write
    step(1'b1, 1'b1, 1'b1, 4'd3, 32'hAAAA_AAAA, 4'd3, 4'd3);
    idle(16);
    for (int i = 0; i < 16; i++) begin a = 4'(i); b = 4'(15 - i); rd(a, b); end

    // reset in the middle of a sweep
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hDEAD_BEEF + 32'(i), 4'(i), 4'(15 - i));
    step(1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    idle(7);
    step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    idle(16);
    for (int i = 0; i < 16; i++) begin a = 4'(i); b = 4'(15 - i); rd(a, b); end

    // randomized traffic with occasional clear and reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(127) != 0), ($urandom_range(63) == 0), 1'($urandom_range(1)),
           4'($urandom_range(15)), $urandom, 4'($urandom_range(15)), 4'($urandom_range(15)));
    end

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file: one synchronous write port, two registered read ports with write-first bypass, and a self-clearing initialisation sequencer. It is the general-purpose register storage of the datapath, replacing the fixed 16x32 decoder/register/mux arrangement. It adds explicit reset, registered reads, same-cycle forwarding, an optional hard-wired zero register, and a software-triggered clear sweep.

## Interface
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 16, number of registers; power of two, >=2
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 0, if 1 register 0 always reads 0 and ignores writes
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- clear  input  1  request a full clear sweep (accepted only in RUN)
- ld  input  1  write enable
- d_select  input  ADDR_W  write address
- input_data  input  WIDTH  write data
- m1_select  input  ADDR_W  read port 1 address
- m2_select  input  ADDR_W  read port 2 address
- rdata1  output  WIDTH  read port 1 data, registered
- rdata2  output  WIDTH  read port 2 data, registered
- ready  output  1  high in RUN state; writes/reads valid only when high

## Operation
- FSM states: INIT (clear sweep), RUN.
- Reset (rst_n low at an edge): state=INIT, sweep counter cnt=0, rdata1=rdata2=0, ready=0. Storage is not cleared by reset itself; the sweep clears it.
- INIT: each edge writes 0 to mem[cnt], cnt++. At the edge where cnt==DEPTH-1: clear last entry, cnt wraps to 0, state->RUN. ld and clear ignored; rdata1/rdata2 forced to 0.
- RUN: if ld, mem[d_select]<=input_data (suppressed when ZERO_REG=1 and d_select==0). If clear, state->INIT, cnt=0; a ld in that same cycle is discarded.
- Read, RUN only: rdataN <= (ld && d_select==mN_select && write not suppressed) ? input_data : mem[mN_select]. With ZERO_REG=1 and mN_select==0, rdataN<=0.
- Both read ports are independent; same address on both ports is legal.
- No arithmetic beyond the counter; cnt is ADDR_W bits wide and wraps naturally.

## Timing
- Read latency: 1 cycle. Address presented before edge k is reflected in rdataN after edge k.
- Write-first bypass: a write and a read of the same address at edge k return the new data after edge k. A write at edge k is visible from storage for reads at edge k+1 onward.
- Init duration: ready rises after the DEPTH-th edge with rst_n high (16 cycles at default). ready is registered and changes with state.
- clear in RUN at edge k: ready=0 after edge k; the sweep occupies edges k+1..k+DEPTH; ready=1 after edge k+DEPTH.
- rst_n low during INIT: the sweep restarts from cnt=0.
- rst_n low has priority over clear and ld.

## Structure
- Shared package regfile_pkg: state enum {INIT, RUN}, default WIDTH/DEPTH constants.
- One natural sub-module: regfile_rd_port (mux + bypass compare + output register), instantiated twice. Storage array, write logic and FSM stay in the top module.

## Test plan
- Reset then idle: ready=0 for 16 cycles, then 1; rdata1/rdata2=0 throughout; all 16 registers read back 0.
- Fill: write r[i]=0xFFFFFF00+i for i=0..15. Sweep reads with m1_select ascending and m2_select descending. Each port returns the matching value one cycle after its address is presented.
- Bypass: r5=0x11111111. In one cycle, ld=1, d_select=5, input_data=0xDEADBEEF, m1_select=m2_select=5. Both ports return 0xDEADBEEF the next cycle.
- ZERO_REG=1: write 0x12345678 to address 0, including a same-cycle read of 0. Reads return 0. A write to address 1 works normally.
- Clear mid-operation: registers filled, clear=1 together with ld to r3=0xAAAAAAAA. The write is dropped, ready=0 for 16 cycles, then all registers read 0.
- Reset mid-sweep: rst_n low at sweep cycle 7 for one cycle. ready stays 0 for a full 16 further cycles; the 0xDEADBEEF+n pattern in r0..r15 is fully erased.
